// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter in front of the single 32-bit memory port of the
//   MIPS core. Requester 0 is instruction fetch and requester 1 is load/store.
//   The arbiter picks one requester, drives the 2:1 address/write-data mux
//   select and registers that requester's address, data and write enable.
//   It then runs a req/ready handshake with a wait timeout, and answers the
//   requester with a one-cycle ack (done) or err (timeout) pulse.
//
// Ports
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   req*/addr*/wdata*/we*  requester side (index 0 = fetch, 1 = load/store)
//   ack*, err*          one-cycle completion / timeout pulses
//   rdata               read data, valid while ack0 or ack1 is high
//   sel                 mux select, 0 = requester 0, 1 = requester 1
//   mem_req/addr/wdata/we  registered memory-side access
//   mem_ready, mem_rdata   memory completion and read data
//
// Parameters
//   MAX_WAIT            number of BUSY cycles without mem_ready before the
//                       access is aborted (1..255)

module mem_port_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Last BUSY value of wait_cnt before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic       state;
    logic       last_grant;
    logic [7:0] wait_cnt;

    // Arbitration and the requester-side 2:1 muxes.
    logic        any_req;
    logic        gnt_idx;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_wdata;
    logic        gnt_we;
    logic        turnaround;

    always_comb begin
        any_req = req0 | req1;
        // Under contention the requester that was not served last goes
        // next; otherwise the single active requester wins.
        if (req0 && req1)
            gnt_idx = ~last_grant;
        else
            gnt_idx = req1;
        gnt_addr  = gnt_idx ? addr1  : addr0;
        gnt_wdata = gnt_idx ? wdata1 : wdata0;
        gnt_we    = gnt_idx ? we1    : we0;
        // The cycle that carries the ack/err pulse is a forced idle cycle.
        // The requester is still holding req at that point and only
        // drops it once it has seen the pulse.
        turnaround = ack0 | ack1 | err0 | err1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            sel        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            rdata      <= 32'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            // Response pulses last one cycle by default.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A mem_ready seen here is ignored.
                    if (any_req && !turnaround) begin
                        sel        <= gnt_idx;
                        mem_addr   <= gnt_addr;
                        mem_wdata  <= gnt_wdata;
                        mem_we     <= gnt_we;
                        mem_req    <= 1'b1;
                        last_grant <= gnt_idx;
                        wait_cnt   <= 8'd0;
                        state      <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // Requester inputs are ignored here. A dropped req does
                    // not cancel the access. mem_ready takes priority over
                    // the timeout when both happen in the same cycle.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (sel) ack1 <= 1'b1;
                        else     ack0 <= 1'b1;
                        if (!mem_we) rdata <= mem_rdata;
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_req <= 1'b0;
                        if (sel) err1 <= 1'b1;
                        else     err0 <= 1'b1;
                        state <= ST_IDLE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        sel, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;
    logic multi_hot = 1'b0;

    mem_port_arbiter #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .sel(sel),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // At most one response pulse may be high in any cycle.
    always @(negedge clk)
        if ((int'(ack0) + int'(ack1) + int'(err0) + int'(err1)) > 1) multi_hot = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge. Outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  n;
    logic seen;
    logic exp_sel;

    initial begin
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 32'h0000_0040; addr1 = 32'h0000_1000;
        wdata0 = 32'h0; wdata1 = 32'h0;
        we0 = 1'b0; we1 = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset with both requesters active: no grant, all outputs zero.
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_resp", {28'd0, ack0, ack1, err0, err1}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        // Release: requester 0 wins first. The single-read case follows.
        reset_n = 1'b1;
        tick();
        chk("first_sel", 32'(sel), 32'd0);
        chk("first_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h0000_0040);
        req1 = 1'b0;
        tick();                                   // first BUSY edge, no ready
        chk("rd_wait_req", 32'(mem_req), 32'd1);
        chk("rd_wait_ack", 32'(ack0), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_ack0", 32'(ack0), 32'd1);
        chk("rd_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd_ack1_err0", {30'd0, ack1, err0}, 32'd0);
        chk("rd_mem_req_off", 32'(mem_req), 32'd0);
        req0 = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
        tick();
        chk("rd_ack_pulse", 32'(ack0), 32'd0);
        chk("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Timeout: the lone requester 1 gets no mem_ready.
        req1 = 1'b1; addr1 = 32'h0000_1000; we1 = 1'b0;
        tick();
        chk("to_sel", 32'(sel), 32'd1);
        n = 1; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack1) seen = 1'b1;
            if (mem_req) n++;
            else break;
        end
        chk("to_req_cycles", 32'(n), 32'd15);
        chk("to_err1", 32'(err1), 32'd1);
        chk("to_no_ack", {31'd0, seen | ack1}, 32'd0);
        req1 = 1'b0;
        tick();
        chk("to_err_pulse", {30'd0, err1, mem_req}, 32'd0);

        // mem_ready arrives in the same cycle as the timeout: ack wins.
        req1 = 1'b1;
        tick();
        chk("edge_sel", 32'(sel), 32'd1);
        repeat (14) tick();
        chk("edge_still_busy", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("edge_ack1", 32'(ack1), 32'd1);
        chk("edge_no_err", 32'(err1), 32'd0);
        chk("edge_rdata", rdata, 32'hCAFE_F00D);
        req1 = 1'b0; mem_ready = 1'b0;
        tick();
        chk("edge_quiet", {30'd0, ack1, err1}, 32'd0);

        // Contention with zero-wait memory: grants alternate 0,1,0,1.
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 32'h0000_0200; we0 = 1'b0;
        addr1 = 32'h0000_1000; wdata1 = 32'hF0F0_F0F0; we1 = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            exp_sel = i[0];
            tick();                               // grant edge
            chk($sformatf("ct%0d_sel", i), 32'(sel), 32'(exp_sel));
            chk($sformatf("ct%0d_mem_req", i), 32'(mem_req), 32'd1);
            if (exp_sel) begin
                chk($sformatf("ct%0d_wdata", i), mem_wdata, 32'hF0F0_F0F0);
                chk($sformatf("ct%0d_we", i), 32'(mem_we), 32'd1);
                chk($sformatf("ct%0d_addr", i), mem_addr, 32'h0000_1000);
            end else begin
                chk($sformatf("ct%0d_we", i), 32'(mem_we), 32'd0);
                chk($sformatf("ct%0d_addr", i), mem_addr, 32'h0000_0200);
            end
            tick();                               // ready edge
            chk($sformatf("ct%0d_acks", i), {30'd0, ack1, ack0},
                exp_sel ? 32'd2 : 32'd1);
            chk($sformatf("ct%0d_rdata", i), rdata, 32'h1234_5678);
            tick();                               // turnaround edge
            chk($sformatf("ct%0d_idle", i), 32'(mem_req), 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;

        // A req drop during BUSY does not cancel the access.
        req0 = 1'b1; addr0 = 32'h0000_0300; we0 = 1'b0;
        tick();
        chk("drop_sel", 32'(sel), 32'd0);
        req0 = 1'b0;
        tick(); tick();
        chk("drop_busy", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        chk("drop_ack0", 32'(ack0), 32'd1);
        chk("drop_rdata", rdata, 32'h55AA_55AA);
        mem_ready = 1'b0;
        tick();

        // Reset during BUSY abandons the access without any response.
        req1 = 1'b1; addr1 = 32'h0000_2000; wdata1 = 32'h0BAD_0BAD; we1 = 1'b1;
        tick();
        chk("mrst_busy", {30'd0, sel, mem_req}, 32'd3);
        req1 = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_mem_req", 32'(mem_req), 32'd0);
        chk("mrst_addr", mem_addr, 32'd0);
        chk("mrst_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        mem_ready = 1'b1;                         // must be ignored while IDLE
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ack0 | ack1 | err0 | err1 | mem_req) seen = 1'b1;
        end
        chk("mrst_no_resp", 32'(seen), 32'd0);
        mem_ready = 1'b0;

        chk("one_hot_resp", 32'(multi_hot), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
